mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes the registered EX/MEM pipeline word and owns the data-memory handshake.
- Stalls upstream while a load/store is outstanding, extracts and extends load data, and produces the registered MEM/WB word.
- The MEM/WB word also serves as the MEM/WB forwarding source for execute.

Parameters:
- none (word width fixed at 32, types from rv32i_types)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_mem_reg  in  ex_mem_reg_t  registered EX/MEM word (dmem_addr word-aligned, rmask/wmask/wdata/dmem_shift_bits/funct3/rd_s/rd_v/regf_we/commit/bubble/pc/pc_next/inst/rs1_s/rs2_s/rs1_v/rs2_v)
- ex_mem_valid  in  1  EX/MEM word holds a live instruction (not bubble)
- mem_ready  out  1  stage accepts ex_mem_reg this cycle; upstream freezes when low
- dmem_addr  out  32  word-aligned data address
- dmem_rmask  out  4  read byte mask, 0 = no read
- dmem_wmask  out  4  write byte mask, 0 = no write
- dmem_wdata  out  32  store data, already lane-aligned
- dmem_rdata  in  32  memory read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion pulse
- mem_wb_reg  out  mem_wb_reg_t  registered MEM/WB word
- mem_wb_valid  out  1  mem_wb_reg holds a live instruction

Behaviour:
- Reset (async, rst_n=0):
  - state=S_IDLE, mem_wb_valid=0, mem_wb_reg all-zero (regf_we=0, commit=0).
  - Latched request cleared; dmem_rmask=dmem_wmask=0, dmem_addr=dmem_wdata=0.
  - mem_ready=1 once out of reset.
- States: S_IDLE, S_WAIT.
- S_IDLE:
  - mem_ready=1.
  - Accept = ex_mem_valid & ~ex_mem_reg.bubble.
  - Accepted op with rmask|wmask != 0:
    - Drive dmem_* combinationally from ex_mem_reg in the same cycle.
    - Latch the word and its masks; next state S_WAIT.
    - mem_wb_valid<=0 next edge.
  - Accepted non-memory op: mem_wb_reg<=ex_mem_reg fields (rd_v, regf_we, commit unchanged), mem_wb_valid<=1. Latency 1 cycle; stay in S_IDLE.
  - No accept: mem_wb_valid<=0, mem_wb_reg.commit<=0, regf_we<=0.
  - dmem_resp in S_IDLE is spurious and ignored.
- S_WAIT:
  - mem_ready=0.
  - dmem_* driven from latched copy, held stable every cycle until dmem_resp.
  - dmem_resp is never expected in the same cycle as the request's first assertion (earliest the following cycle).
  - On dmem_resp:
    - Write mem_wb_reg from latch and set mem_wb_valid<=1, commit<=1.
    - dmem masks drop to 0 the next cycle; next state S_IDLE.
    - Loads: regf_we<=1, rd_v from load extraction below. Stores: regf_we<=0.
  - Without dmem_resp: mem_wb_valid<=0, commit<=0.
- Load extraction (sh = latched dmem_shift_bits):
  - lb: sign-extend rdata[8*sh +: 8]; lbu: zero-extend same byte.
  - lh: sign-extend rdata[16*sh[1] +: 16]; lhu: zero-extend same half.
  - lw: rdata.
- RVFI fields in mem_wb_reg: dmem_addr, rmask, wmask, wdata, rdata copied. rdata=0 for non-loads.
- Back-to-back: a new word may be accepted in the same cycle S_WAIT→S_IDLE? No. The transition happens at the edge; the next word is accepted the following cycle. Throughput is one memory op per (resp latency + 1) cycles.
- Reset during S_WAIT:
  - Abandons the op; no commit.
  - A late dmem_resp after reset release is ignored.

Test Plan:
- ALU pass-through: addi word rd_s=5, rd_v=0x5, regf_we=1, masks 0 → next cycle mem_wb_valid=1, rd_v=0x5, commit=1; mem_ready stays 1.
- lb sign/zero extension: dmem_addr=0x1000, rmask=4'b1000, sh=3, resp 3 cycles later with rdata=0x80FFFFFF.
  - mem_ready=0 for 3 cycles; rmask/addr held at 4'b1000/0x1000.
  - Result rd_v=0xFFFFFF80; with lbu → 0x00000080.
- Halfword loads: rdata=0x80011234, sh=2.
  - lh → 0xFFFF8001.
  - lhu → 0x00008001.
  - sh=0 lh → 0x00001234.
- Store: sw wmask=4'b1111, wdata=0xDEADBEEF, resp next cycle → mem_wb_valid=1, commit=1, regf_we=0, wmask recorded 4'b1111, masks 0 the following cycle.
- Reset mid-wait: rst_n low during S_WAIT with rmask=4'b0011 → masks 0, mem_wb_valid=0, mem_ready=1 immediately; dmem_resp after release yields no commit.
- Bubbles and spurious resp: ex_mem_valid=0 for 4 cycles with a dmem_resp pulse in S_IDLE → mem_wb_valid=0, commit=0, state stays S_IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage sitting directly after execute.
//   Takes the registered EX/MEM word, runs the single-outstanding data-memory
//   handshake, extracts and extends load data, and registers the MEM/WB word.
//   That word is also the MEM/WB forwarding source for execute.
//
// Ports:
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   ex_mem_reg            registered EX/MEM word
//   ex_mem_valid          EX/MEM word carries a live instruction
//   mem_ready             stage accepts ex_mem_reg this cycle (upstream freezes when low)
//   dmem_addr/rmask/      data-memory request; masks of zero mean no access
//   wmask/wdata
//   dmem_rdata, dmem_resp read data and one-cycle completion pulse
//   mem_wb_reg            registered MEM/WB word
//   mem_wb_valid          mem_wb_reg carries a live instruction

package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        commit;
    logic        bubble;
    logic [2:0]  funct3;
    logic [31:0] dmem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [1:0]  dmem_shift_bits;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        commit;
    logic [31:0] dmem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_wb_reg_t;

endpackage

module mem_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_reg_t ex_mem_reg,
  input  logic        ex_mem_valid,
  output logic        mem_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output mem_wb_reg_t mem_wb_reg,
  output logic        mem_wb_valid
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state, state_next;
  ex_mem_reg_t req;
  logic        accept;
  logic        is_mem;
  logic        issue;
  logic [31:0] load_data;
  mem_wb_reg_t wb_resp;
  logic        unused_bits;

  // funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                               input logic [1:0]  sh,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{sh, 3'b000} +: 8];
    h = rdata[{sh[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic mem_wb_reg_t to_wb(input ex_mem_reg_t w);
    mem_wb_reg_t o;
    o           = '0;
    o.pc        = w.pc;
    o.pc_next   = w.pc_next;
    o.inst      = w.inst;
    o.rs1_s     = w.rs1_s;
    o.rs2_s     = w.rs2_s;
    o.rs1_v     = w.rs1_v;
    o.rs2_v     = w.rs2_v;
    o.rd_s      = w.rd_s;
    o.rd_v      = w.rd_v;
    o.regf_we   = w.regf_we;
    o.commit    = w.commit;
    o.dmem_addr = w.dmem_addr;
    o.rmask     = w.rmask;
    o.wmask     = w.wmask;
    o.wdata     = w.wdata;
    return o;
  endfunction

  // The latched copy never carries a bubble, so that bit is not consumed.
  assign unused_bits = req.bubble;

  assign load_data = load_extract(req.funct3, req.dmem_shift_bits, dmem_rdata);

  // Completion word: loads write back extracted data, stores only commit.
  always_comb begin
    wb_resp        = to_wb(req);
    wb_resp.commit = 1'b1;
    if (|req.rmask) begin
      wb_resp.regf_we = 1'b1;
      wb_resp.rd_v    = load_data;
      wb_resp.rdata   = dmem_rdata;
    end else begin
      wb_resp.regf_we = 1'b0;
    end
  end

  // Request side: in S_IDLE the request goes out combinationally in the accept
  // cycle; in S_WAIT it is replayed from the latch until the response arrives.
  always_comb begin
    accept     = ex_mem_valid & ~ex_mem_reg.bubble;
    is_mem     = |(ex_mem_reg.rmask | ex_mem_reg.wmask);
    issue      = 1'b0;
    state_next = state;
    mem_ready  = 1'b1;
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (accept && is_mem) begin
          issue      = 1'b1;
          state_next = S_WAIT;
          dmem_addr  = ex_mem_reg.dmem_addr;
          dmem_rmask = ex_mem_reg.rmask;
          dmem_wmask = ex_mem_reg.wmask;
          dmem_wdata = ex_mem_reg.wdata;
        end
      end
      S_WAIT: begin
        mem_ready  = 1'b0;
        dmem_addr  = req.dmem_addr;
        dmem_rmask = req.rmask;
        dmem_wmask = req.wmask;
        dmem_wdata = req.wdata;
        if (dmem_resp) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // MEM/WB boundary: valid, commit and regf_we drop every cycle nothing retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req          <= '0;
      mem_wb_reg   <= '0;
      mem_wb_valid <= 1'b0;
    end else begin
      state              <= state_next;
      mem_wb_valid       <= 1'b0;
      mem_wb_reg.commit  <= 1'b0;
      mem_wb_reg.regf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            req <= ex_mem_reg;
          end else if (accept) begin
            mem_wb_reg   <= to_wb(ex_mem_reg);
            mem_wb_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (dmem_resp) begin
            mem_wb_reg   <= wb_resp;
            mem_wb_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
